// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline hazard bundle between the datapath and hazard_stall_ctrl.
// master drives pipeline state in, slave returns stall/flush controls.
interface hazard_stall_ctrl_if #(
    parameter int OPW  = 4,
    parameter int REGW = 4
);
    logic [1:0]      hazard_en;
    logic [OPW-1:0]  id_op;
    logic [REGW-1:0] id_rs;
    logic [REGW-1:0] id_rt;
    logic [OPW-1:0]  ex_op;
    logic [OPW-1:0]  mem_op;
    logic [REGW-1:0] ex_rd;
    logic [REGW-1:0] mem_rd;
    logic            ex_wr;
    logic            mem_wr;
    logic            br_taken;
    logic            stall_pc;
    logic            stall_ifid;
    logic            bubble_idex;
    logic            flush_ifid;
    logic            busy;
    logic [31:0]     stall_cycles;
    logic [31:0]     flush_cycles;

    modport master (
        output hazard_en, id_op, id_rs, id_rt,
        output ex_op, mem_op, ex_rd, mem_rd,
        output ex_wr, mem_wr, br_taken,
        input  stall_pc, stall_ifid, bubble_idex,
        input  flush_ifid, busy,
        input  stall_cycles, flush_cycles
    );

    modport slave (
        input  hazard_en, id_op, id_rs, id_rt,
        input  ex_op, mem_op, ex_rd, mem_rd,
        input  ex_wr, mem_wr, br_taken,
        output stall_pc, stall_ifid, bubble_idex,
        output flush_ifid, busy,
        output stall_cycles, flush_cycles
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Hazard / stall / flush controller for the 5-stage pipeline.
// Optional macro HAZ_PERF_CNT_EN adds saturating stall/flush counters.
module hazard_stall_ctrl #(
    parameter int             OPW       = 4,
    parameter int             REGW      = 4,
    parameter int             LOAD_LAT  = 1,
    parameter int             FLUSH_CYC = 1,
    parameter logic [OPW-1:0] OP_ATYPE  = 4'b0001,
    parameter logic [OPW-1:0] OP_LW     = 4'b0110,
    parameter logic [OPW-1:0] OP_LB     = 4'b0100,
    parameter logic [OPW-1:0] OP_BR0    = 4'b1100,
    parameter logic [OPW-1:0] OP_BR1    = 4'b1101,
    parameter logic [OPW-1:0] OP_BR2    = 4'b1110
) (
    input logic clk,
    input logic rst_n,
    hazard_stall_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        STALL,
        FLUSH
    } state_t;

    localparam logic [3:0] LL = 4'(LOAD_LAT);
    localparam logic [3:0] FC = 4'(FLUSH_CYC);

    state_t     state;
    logic [3:0] cnt;

    logic       id_br;
    logic       id_at;
    logic       rd_ex;
    logic       rd_mem;
    logic       lu;
    logic       bm;
    logic       be;
    logic       haz;
    logic [3:0] len;
    logic       stl;
    logic       fls;

    function automatic logic is_load(input logic [OPW-1:0] op);
        return (op == OP_LW) || (op == OP_LB);
    endfunction

    // Hazard detection by register-address match; r0 never hazards.
    always_comb begin
        id_br  = (bus.id_op == OP_BR0) || (bus.id_op == OP_BR1) ||
                 (bus.id_op == OP_BR2);
        id_at  = (bus.id_op == OP_ATYPE);
        rd_ex  = (bus.ex_rd != '0) &&
                 ((bus.id_rs == bus.ex_rd) || (bus.id_rt == bus.ex_rd));
        rd_mem = (bus.mem_rd != '0) &&
                 ((bus.id_rs == bus.mem_rd) || (bus.id_rt == bus.mem_rd));
        lu     = bus.hazard_en[0] && (id_at || id_br) &&
                 is_load(bus.ex_op) && bus.ex_wr && rd_ex;
        bm     = bus.hazard_en[1] && id_br &&
                 is_load(bus.mem_op) && bus.mem_wr && rd_mem;
        be     = bus.hazard_en[1] && id_br && bus.ex_wr &&
                 !is_load(bus.ex_op) && rd_ex;
        haz    = lu || bm || be;
        // LU and BM both wait on a load; BE only needs one cycle.
        len    = (lu || bm) ? LL : 4'd1;
    end

    // Same-cycle stall/flush in IDLE, held while in STALL/FLUSH.
    always_comb begin
        stl = 1'b0;
        fls = 1'b0;
        if (rst_n) begin
            stl = (state == STALL) || ((state == IDLE) && haz);
            fls = (state == FLUSH) ||
                  ((state == IDLE) && !haz && bus.br_taken);
        end
    end

    assign bus.stall_pc    = stl;
    assign bus.stall_ifid  = stl;
    assign bus.bubble_idex = stl;
    assign bus.flush_ifid  = fls;
    assign bus.busy        = rst_n && (state != IDLE);

    // Stall/flush sequencer; the first stall/flush cycle happens in IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (haz) begin
                        if (len > 4'd1) begin
                            state <= STALL;
                            cnt   <= len - 4'd2;
                        end
                    end else if (bus.br_taken && (FC > 4'd1)) begin
                        state <= FLUSH;
                        cnt   <= FC - 4'd2;
                    end
                end
                STALL, FLUSH: begin
                    if (cnt == 4'd0) state <= IDLE;
                    else             cnt   <= cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] sc;
    logic [31:0] fc_q;

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sc   <= '0;
            fc_q <= '0;
        end else begin
            if (stl && (sc != '1))   sc   <= sc + 32'd1;
            if (fls && (fc_q != '1)) fc_q <= fc_q + 32'd1;
        end
    end

    assign bus.stall_cycles = sc;
    assign bus.flush_cycles = fc_q;
`else
    assign bus.stall_cycles = '0;
    assign bus.flush_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: three instances (LOAD_LAT 1/3/4,
// FLUSH_CYC 1/2/1) share stimulus; each has its own expected column.
module tb_hazard_stall_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl_if #(.OPW(4), .REGW(4)) i1 ();
    hazard_stall_ctrl_if #(.OPW(4), .REGW(4)) i3 ();
    hazard_stall_ctrl_if #(.OPW(4), .REGW(4)) i4 ();

    hazard_stall_ctrl #(.LOAD_LAT(1), .FLUSH_CYC(1)) d1 (
        .clk(clk), .rst_n(rst_n), .bus(i1)
    );
    hazard_stall_ctrl #(.LOAD_LAT(3), .FLUSH_CYC(2)) d3 (
        .clk(clk), .rst_n(rst_n), .bus(i3)
    );
    hazard_stall_ctrl #(.LOAD_LAT(4), .FLUSH_CYC(1)) d4 (
        .clk(clk), .rst_n(rst_n), .bus(i4)
    );

    localparam logic [3:0] NOP = 4'b0000;
    localparam logic [3:0] AT  = 4'b0001;
    localparam logic [3:0] LW  = 4'b0110;
    localparam logic [3:0] LB  = 4'b0100;
    localparam logic [3:0] B0  = 4'b1100;
    localparam logic [3:0] B1  = 4'b1101;
    localparam logic [3:0] B2  = 4'b1110;

    // {stall_pc, stall_ifid, bubble_idex, flush_ifid, busy}
    localparam logic [4:0] Q  = 5'b00000;
    localparam logic [4:0] SI = 5'b11100;
    localparam logic [4:0] SS = 5'b11101;
    localparam logic [4:0] FI = 5'b00010;
    localparam logic [4:0] FS = 5'b00011;

    typedef struct {
        logic [1:0] en;
        logic [3:0] iop, rs, rt;
        logic [3:0] eop, erd;
        logic       ewr;
        logic [3:0] mop, mrd;
        logic       mwr, br;
        logic [4:0] e1, e3, e4;
    } vec_t;

    vec_t        tv[31];
    logic [14:0] sb[$];

    function automatic vec_t mk(
        input logic [1:0] en, input logic [3:0] iop,
        input logic [3:0] rs, input logic [3:0] rt,
        input logic [3:0] eop, input logic [3:0] erd,
        input logic ewr, input logic [3:0] mop,
        input logic [3:0] mrd, input logic mwr, input logic br,
        input logic [4:0] e1, input logic [4:0] e3,
        input logic [4:0] e4);
        vec_t v;
        v.en = en; v.iop = iop; v.rs = rs; v.rt = rt;
        v.eop = eop; v.erd = erd; v.ewr = ewr;
        v.mop = mop; v.mrd = mrd; v.mwr = mwr; v.br = br;
        v.e1 = e1; v.e3 = e3; v.e4 = e4;
        return v;
    endfunction

    function automatic vec_t nop(input logic [4:0] e1,
        input logic [4:0] e3, input logic [4:0] e4);
        return mk(2'b00, NOP, 0, 0, NOP, 0, 0, NOP, 0, 0, 0,
                  e1, e3, e4);
    endfunction

    task automatic drive(input vec_t v);
        i1.hazard_en = v.en; i3.hazard_en = v.en; i4.hazard_en = v.en;
        i1.id_op = v.iop; i3.id_op = v.iop; i4.id_op = v.iop;
        i1.id_rs = v.rs; i3.id_rs = v.rs; i4.id_rs = v.rs;
        i1.id_rt = v.rt; i3.id_rt = v.rt; i4.id_rt = v.rt;
        i1.ex_op = v.eop; i3.ex_op = v.eop; i4.ex_op = v.eop;
        i1.ex_rd = v.erd; i3.ex_rd = v.erd; i4.ex_rd = v.erd;
        i1.ex_wr = v.ewr; i3.ex_wr = v.ewr; i4.ex_wr = v.ewr;
        i1.mem_op = v.mop; i3.mem_op = v.mop; i4.mem_op = v.mop;
        i1.mem_rd = v.mrd; i3.mem_rd = v.mrd; i4.mem_rd = v.mrd;
        i1.mem_wr = v.mwr; i3.mem_wr = v.mwr; i4.mem_wr = v.mwr;
        i1.br_taken = v.br; i3.br_taken = v.br; i4.br_taken = v.br;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [4:0] o1();
        return {i1.stall_pc, i1.stall_ifid, i1.bubble_idex,
                i1.flush_ifid, i1.busy};
    endfunction
    function automatic logic [4:0] o3();
        return {i3.stall_pc, i3.stall_ifid, i3.bubble_idex,
                i3.flush_ifid, i3.busy};
    endfunction
    function automatic logic [4:0] o4();
        return {i4.stall_pc, i4.stall_ifid, i4.bubble_idex,
                i4.flush_ifid, i4.busy};
    endfunction

    task automatic apply(input string nm, input vec_t v);
        logic [14:0] e;
        @(posedge clk);
        #1;
        drive(v);
        sb.push_back({v.e1, v.e3, v.e4});
        @(negedge clk);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = sb.pop_front();
            chk({nm, "/lat1"}, 32'(o1()), 32'(e[14:10]));
            chk({nm, "/lat3"}, 32'(o3()), 32'(e[9:5]));
            chk({nm, "/lat4"}, 32'(o4()), 32'(e[4:0]));
        end
    endtask

    initial begin
        tv[0]  = nop(Q, Q, Q);
        tv[1]  = mk(2'b01, AT, 3, 0, LW, 3, 1, NOP, 0, 0, 0,
                    SI, SI, SI);
        tv[2]  = nop(Q, SS, SS);
        tv[3]  = nop(Q, SS, SS);
        tv[4]  = nop(Q, Q, SS);
        tv[5]  = nop(Q, Q, Q);
        tv[6]  = mk(2'b10, B1, 0, 5, AT, 5, 1, NOP, 0, 0, 0,
                    SI, SI, SI);
        tv[7]  = mk(2'b10, B1, 0, 5, NOP, 0, 0, AT, 5, 1, 0,
                    Q, Q, Q);
        tv[8]  = mk(2'b11, B0, 0, 0, LW, 0, 1, NOP, 0, 0, 0,
                    Q, Q, Q);
        tv[9]  = mk(2'b00, B0, 2, 0, LW, 2, 1, NOP, 0, 0, 0,
                    Q, Q, Q);
        tv[10] = mk(2'b11, B2, 7, 0, NOP, 0, 0, NOP, 0, 0, 1,
                    FI, FI, FI);
        tv[11] = mk(2'b10, B0, 6, 0, AT, 6, 1, NOP, 0, 0, 0,
                    SI, FS, SI);
        tv[12] = mk(2'b10, B0, 6, 0, AT, 6, 1, NOP, 0, 0, 1,
                    SI, SI, SI);
        tv[13] = nop(Q, Q, Q);
        tv[14] = mk(2'b10, B2, 9, 0, NOP, 0, 0, LB, 9, 1, 0,
                    SI, SI, SI);
        tv[15] = mk(2'b10, B2, 9, 0, NOP, 0, 0, LB, 9, 1, 1,
                    SI, SS, SS);
        tv[16] = nop(Q, SS, SS);
        tv[17] = nop(Q, Q, SS);
        tv[18] = nop(Q, Q, Q);
        tv[19] = mk(2'b10, B0, 4, 8, AT, 4, 1, LW, 8, 1, 0,
                    SI, SI, SI);
        tv[20] = nop(Q, SS, SS);
        tv[21] = nop(Q, SS, SS);
        tv[22] = nop(Q, Q, SS);
        tv[23] = nop(Q, Q, Q);
        tv[24] = mk(2'b01, LW, 3, 0, LW, 3, 1, NOP, 0, 0, 0,
                    Q, Q, Q);
        tv[25] = mk(2'b11, AT, 3, 0, LW, 3, 0, NOP, 0, 0, 0,
                    Q, Q, Q);
        tv[26] = mk(2'b01, AT, 0, 7, LB, 7, 1, NOP, 0, 0, 0,
                    SI, SI, SI);
        tv[27] = nop(Q, SS, SS);
        tv[28] = nop(Q, SS, SS);
        tv[29] = nop(Q, Q, SS);
        tv[30] = nop(Q, Q, Q);

        // Reset with a live hazard and branch: outputs forced low.
        rst_n = 1'b0;
        drive(mk(2'b11, AT, 3, 0, LW, 3, 1, NOP, 0, 0, 1, Q, Q, Q));
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst/lat1", 32'(o1()), 32'(Q));
        chk("rst/lat3", 32'(o3()), 32'(Q));
        chk("rst/lat4", 32'(o4()), 32'(Q));
        chk("rst/cnt", i4.stall_cycles, 32'd0);
        @(posedge clk);
        #1;
        drive(tv[0]);
        rst_n = 1'b1;

        for (int k = 0; k < 31; k++) begin
            apply($sformatf("vec%0d", k), tv[k]);
        end

        // Reset in the 2nd stall cycle of a LOAD_LAT=4 stall.
        apply("midrst_a", tv[1]);
        @(posedge clk);
        #1;
        drive(tv[0]);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_b/lat3", 32'(o3()), 32'(Q));
        chk("midrst_b/lat4", 32'(o4()), 32'(Q));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_c/lat4", 32'(o4()), 32'(Q));
        chk("midrst_c/lat3", 32'(o3()), 32'(Q));
        chk("perf_clr", i4.stall_cycles, 32'd0);

        // One uninterrupted load-use stall, then counter values.
        for (int k = 1; k <= 5; k++) begin
            apply($sformatf("perf%0d", k), tv[k]);
        end
`ifdef HAZ_PERF_CNT_EN
        chk("stall_cycles/lat4", i4.stall_cycles, 32'd4);
        chk("stall_cycles/lat3", i3.stall_cycles, 32'd3);
        chk("stall_cycles/lat1", i1.stall_cycles, 32'd1);
`else
        chk("stall_cycles/lat4", i4.stall_cycles, 32'd0);
        chk("stall_cycles/lat3", i3.stall_cycles, 32'd0);
`endif
        chk("flush_cycles/lat3", i3.flush_cycles, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
